// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 4-digit scan controller: blanking gap, one-hot anode drive, per-frame snapshot.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module digit_scan_ctrl #(
    parameter logic [15:0] PRESCALE  = 16'd1000,
    parameter logic [15:0] BLANK_CYC = 16'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    output logic [1:0]  sel,
    output logic [3:0]  an,
    output logic [3:0]  bcd_out,
    output logic        dp_out,
    output logic        frame_tick
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_e;

    localparam logic [15:0] CNT_LAST   = PRESCALE - 16'd1;
    localparam logic [15:0] BLANK_LAST = BLANK_CYC - 16'd1;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  sel_q, sel_d;
    logic [15:0] snap_q, snap_d;
    logic [3:0]  snapdp_q, snapdp_d;
    logic [3:0]  an_q, an_d;
    logic [3:0]  bcd_q, bcd_d;
    logic        dp_q, dp_d;
    logic        tick_q, tick_d;

    function automatic logic [3:0] onehot4(input logic [1:0] i);
        case (i)
            2'd0:    onehot4 = 4'b0001;
            2'd1:    onehot4 = 4'b0010;
            2'd2:    onehot4 = 4'b0100;
            2'd3:    onehot4 = 4'b1000;
            default: onehot4 = 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] digit_at(input logic [15:0] s, input logic [1:0] i);
        case (i)
            2'd0:    digit_at = s[3:0];
            2'd1:    digit_at = s[7:4];
            2'd2:    digit_at = s[11:8];
            2'd3:    digit_at = s[15:12];
            default: digit_at = s[3:0];
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is hidden when it and every digit above it are zero; digit 0 never is.
    function automatic logic lz_hidden(input logic [15:0] s, input logic [1:0] i);
        case (i)
            2'd3:    lz_hidden = (s[15:12] == 4'd0);
            2'd2:    lz_hidden = (s[15:8] == 8'd0);
            2'd1:    lz_hidden = (s[15:4] == 12'd0);
            default: lz_hidden = 1'b0;
        endcase
    endfunction
`endif

    // Scan sequencing: slot counter, digit index and frame snapshot.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        snap_d   = snap_q;
        snapdp_d = snapdp_q;
        if (!en) begin
            state_d = ST_OFF;
            cnt_d   = 16'd0;
            sel_d   = 2'd0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d  = ST_BLANK;
                    cnt_d    = 16'd0;
                    sel_d    = 2'd0;
                    snap_d   = digits_in;
                    snapdp_d = dp_in;
                end
                ST_BLANK: begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                    end else begin
                        state_d = ST_BLANK;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = 16'd0;
                        sel_d   = sel_q + 2'd1;
                        // New inputs are only taken at a frame boundary so a frame never tears.
                        if (sel_q == 2'd3) begin
                            snap_d   = digits_in;
                            snapdp_d = dp_in;
                        end else begin
                            snap_d   = snap_q;
                            snapdp_d = snapdp_q;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = 16'd0;
                    sel_d   = 2'd0;
                end
            endcase
        end
    end

    // Output values derived from the next state so the registered outputs line up with it.
    always_comb begin
        an_d   = 4'b0000;
        bcd_d  = bcd_q;
        dp_d   = 1'b0;
        tick_d = 1'b0;
        if (state_d == ST_SHOW) begin
            bcd_d  = digit_at(snap_d, sel_d);
            tick_d = (sel_d == 2'd3) && (cnt_d == CNT_LAST);
`ifdef LEADING_ZERO_BLANK_EN
            if (lz_hidden(snap_d, sel_d)) begin
                an_d = 4'b0000;
                dp_d = 1'b0;
            end else begin
                an_d = onehot4(sel_d);
                dp_d = snapdp_d[sel_d];
            end
`else
            an_d = onehot4(sel_d);
            dp_d = snapdp_d[sel_d];
`endif
        end else begin
            an_d   = 4'b0000;
            dp_d   = 1'b0;
            tick_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_OFF;
            cnt_q    <= 16'd0;
            sel_q    <= 2'd0;
            snap_q   <= 16'd0;
            snapdp_q <= 4'd0;
            an_q     <= 4'd0;
            bcd_q    <= 4'd0;
            dp_q     <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            snap_q   <= snap_d;
            snapdp_q <= snapdp_d;
            an_q     <= an_d;
            bcd_q    <= bcd_d;
            dp_q     <= dp_d;
            tick_q   <= tick_d;
        end
    end

    assign sel        = sel_q;
    assign an         = an_q;
    assign bcd_out    = bcd_q;
    assign dp_out     = dp_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl: expected slot contents are queued by the stimulus
// and popped by a monitor at each anode onset; invariants are checked every cycle.
module tb_digit_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [1:0]  sel;
    logic [3:0]  an;
    logic [3:0]  bcd_out;
    logic        dp_out;
    logic        frame_tick;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] bcd;
        logic       dp;
    } slot_t;

    slot_t q[$];
    int    chk_cnt  = 0;
    int    pass_cnt = 0;
    int    tick_cnt = 0;

    digit_scan_ctrl #(.PRESCALE(16'd8), .BLANK_CYC(16'd2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .sel       (sel),
        .an        (an),
        .bcd_out   (bcd_out),
        .dp_out    (dp_out),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic timeout(input string name);
        chk_cnt++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b, input logic d);
        slot_t s;
        s.an = a; s.bcd = b; s.dp = d;
        q.push_back(s);
    endtask

    task automatic wait_an(input logic [3:0] val, input int bound, input string name);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk); #1;
            if (an == val) return;
        end
        timeout(name);
    endtask

    task automatic wait_q_empty(input int bound, input string name);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk); #1;
            if (q.size() == 0) return;
        end
        timeout(name);
    endtask

    task automatic wait_tick(input int bound, input string name);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk); #1;
            if (frame_tick) return;
        end
        timeout(name);
    endtask

    // Monitor: per-cycle invariants, slot scoreboard and frame_tick cadence.
    initial begin
        logic [3:0] an_prev;
        logic [3:0] last_nz;
        int         zero_run;
        int         cyc;
        int         last_tick;
        bit         tick_valid;
        slot_t      e;
        an_prev = 4'd0; last_nz = 4'd0; zero_run = 0; cyc = 0; last_tick = 0; tick_valid = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            check("an_legal", 32'(an inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000}), 32'd1);
            if (an != 4'd0) begin
                if (last_nz != 4'd0 && an != last_nz) check("an_gap", 32'(zero_run >= 2), 32'd1);
                last_nz  = an;
                zero_run = 0;
                if (an_prev == 4'd0) begin
                    if (q.size() == 0) begin
                        chk_cnt++;
                        $display("FAIL slot_unexpected: an=%b bcd=%h with nothing expected at %0t", an, bcd_out, $time);
                    end else begin
                        e = q.pop_front();
                        check("slot_an", 32'(an), 32'(e.an));
                        check("slot_bcd", 32'(bcd_out), 32'(e.bcd));
                        check("slot_dp", 32'(dp_out), 32'(e.dp));
                    end
                end
            end else begin
                zero_run++;
            end
            if (frame_tick) begin
                tick_cnt++;
                check("tick_sel", 32'(sel), 32'd3);
                if (tick_valid) check("tick_period", 32'(cyc - last_tick), 32'd32);
                tick_valid = 1'b1;
                last_tick  = cyc;
            end
            if (!en || !rst_n) tick_valid = 1'b0;
            an_prev = an;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        int t0;
        rst_n = 1'b0; en = 1'b0; digits_in = 16'h1234; dp_in = 4'b0100;
        repeat (3) @(negedge clk);
        check("rst_an", 32'(an), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'd0);
        check("rst_dp", 32'(dp_out), 32'd0);
        check("rst_tick", 32'(frame_tick), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("off_an", 32'(an), 32'd0);

        // Scenario 1: first frame 4,3,2(dp),1
        push(4'b0001, 4'h4, 1'b0); push(4'b0010, 4'h3, 1'b0);
        push(4'b0100, 4'h2, 1'b1); push(4'b1000, 4'h1, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            check("start_blank_an", 32'(an), 32'd0);
        end
        @(negedge clk); #1;
        check("start_show_an", 32'(an), 32'b0001);
        check("start_show_bcd", 32'(bcd_out), 32'h4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
        end
        check("slot0_last_an", 32'(an), 32'b0001);
        @(negedge clk); #1;
        check("slot1_blank_an", 32'(an), 32'd0);
        check("slot1_sel", 32'(sel), 32'd1);

        // Scenario 2: mid-frame change appears only from the next frame
        wait_an(4'b0010, 50, "wait_sel1");
        digits_in = 16'h5678;
        t0 = tick_cnt;
        push(4'b0001, 4'h8, 1'b0); push(4'b0010, 4'h7, 1'b0);
        push(4'b0100, 4'h6, 1'b1); push(4'b1000, 4'h5, 1'b0);
        push(4'b0001, 4'h8, 1'b0); push(4'b0010, 4'h7, 1'b0);
        push(4'b0100, 4'h6, 1'b1);
        repeat (64) @(negedge clk);
        #1;
        check("ticks_per_64", 32'(tick_cnt - t0), 32'd2);

        // Scenario 3: drop en during digit 2 display, then restart with fresh snapshot
        wait_an(4'b0100, 60, "wait_sel2");
        en = 1'b0;
        @(negedge clk); #1;
        check("drop_an", 32'(an), 32'd0);
        check("drop_sel", 32'(sel), 32'd0);
        check("drop_tick", 32'(frame_tick), 32'd0);
        check("drop_dp", 32'(dp_out), 32'd0);
        check("drop_bcd_hold", 32'(bcd_out), 32'h6);
        repeat (3) @(negedge clk);
        #1;
        check("off_hold_an", 32'(an), 32'd0);
        digits_in = 16'hFA9C; dp_in = 4'b0001;
        push(4'b0001, 4'hC, 1'b1); push(4'b0010, 4'h9, 1'b0);
        push(4'b0100, 4'hA, 1'b0); push(4'b1000, 4'hF, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            check("restart_blank_an", 32'(an), 32'd0);
        end
        @(negedge clk); #1;
        check("restart_show_an", 32'(an), 32'b0001);
        wait_q_empty(100, "wait_restart_frame");

        // Scenario 4: asynchronous reset between clock edges while digit 3 is lit
        check("pre_rst_an", 32'(an), 32'b1000);
        #1;
        rst_n = 1'b0; en = 1'b0;
        #1;
        check("async_rst_an", 32'(an), 32'd0);
        check("async_rst_sel", 32'(sel), 32'd0);
        check("async_rst_tick", 32'(frame_tick), 32'd0);
        check("async_rst_bcd", 32'(bcd_out), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("post_rst_off_an", 32'(an), 32'd0);
        check("post_rst_off_sel", 32'(sel), 32'd0);

        // Scenario 6: leading zeros (suppressed only when the option is built in)
        digits_in = 16'h0050; dp_in = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
        push(4'b0001, 4'h0, 1'b0); push(4'b0010, 4'h5, 1'b0);
`else
        push(4'b0001, 4'h0, 1'b0); push(4'b0010, 4'h5, 1'b0);
        push(4'b0100, 4'h0, 1'b0); push(4'b1000, 4'h0, 1'b0);
`endif
        en = 1'b1;
        @(negedge clk); #1;
        digits_in = 16'h0000;
`ifdef LEADING_ZERO_BLANK_EN
        push(4'b0001, 4'h0, 1'b0);
`else
        push(4'b0001, 4'h0, 1'b0); push(4'b0010, 4'h0, 1'b0);
        push(4'b0100, 4'h0, 1'b0); push(4'b1000, 4'h0, 1'b0);
`endif
        wait_q_empty(200, "wait_lz_frames");
        wait_tick(64, "wait_lz_tick");
        en = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("end_an", 32'(an), 32'd0);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
